// File: rtl/colour_seq.sv
// Colour sequence store, LFSR colour generator and player-input checker.
// Define SEQ_FIXED_SEED_EN to seed the generator from SEED_INIT on every start.
module colour_seq #(
  parameter int          MAX_LEN   = 32,
  parameter logic [15:0] SEED_INIT = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_seedgen,
  input  logic       start,
  input  logic       load_colour,
  input  logic       flash_clk,
  input  logic [5:0] check_round,
  input  logic [5:0] current_round,
  input  logic [3:0] player_input,
  output logic       result,
  output logic [3:0] leds,
  output logic [5:0] seq_len,
  output logic       full
);

  localparam logic [5:0] LEN = 6'(MAX_LEN);

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [15:0] seed;
  logic [15:0] gen;
  logic [15:0] gen_init;
  logic        seed_run;
  logic [1:0]  mem [MAX_LEN];
  logic        fail_flag;
  logic [3:0]  last_input;
  logic [5:0]  idx;
  logic        idx_ok;
  logic [1:0]  colour;
  logic [3:0]  target;
  logic        hit;
  logic        wr;
  logic        pressed;

  assign full    = (seq_len == LEN);
  assign idx     = current_round - check_round;
  assign idx_ok  = (check_round != 6'd0) &&
                   (check_round <= current_round) &&
                   (idx < seq_len);
  assign target  = 4'b0001 << colour;
  assign hit     = idx_ok && (player_input == target);
  assign pressed = (player_input != 4'd0);
  assign wr      = load_colour && !full && !start && !rst_seedgen;

`ifdef SEQ_FIXED_SEED_EN
  assign gen_init = SEED_INIT;
`else
  assign gen_init = (seed == 16'd0) ? 16'h0001 : seed;
`endif

  always_comb begin
    colour = 2'd0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx == 6'(i)) colour = mem[i];
    end
  end

  always_comb begin
    leds = 4'd0;
    if (flash_clk) begin
      if (fail_flag)   leds = last_input;
      else if (idx_ok) leds = target;
    end
  end

  // Seed free-runs from rst_seedgen until start, so game start timing picks the sequence
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed     <= SEED_INIT;
      seed_run <= 1'b0;
    end else if (rst_seedgen) begin
      seed     <= SEED_INIT;
      seed_run <= 1'b1;
    end else if (start) begin
      seed_run <= 1'b0;
    end else if (seed_run) begin
      seed     <= lfsr_step(seed);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gen     <= 16'h0001;
      seq_len <= 6'd0;
    end else if (rst_seedgen) begin
      gen     <= gen;
    end else if (start) begin
      gen     <= gen_init;
      seq_len <= 6'd0;
    end else if (wr) begin
      gen     <= lfsr_step(gen);
      seq_len <= seq_len + 6'd1;
    end
  end

  // Colour storage survives start; only written entries are ever read back
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_LEN; i++) begin
      if (wr && seq_len == 6'(i)) mem[i] <= gen[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result     <= 1'b0;
      last_input <= 4'd0;
      fail_flag  <= 1'b0;
    end else begin
      if (pressed) begin
        result     <= hit;
        last_input <= player_input;
      end
      if (rst_seedgen || start) fail_flag <= 1'b0;
      else if (pressed && !hit) fail_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_colour_seq.sv
// Directed self-checking bench for colour_seq.
// Expected colours come from a local LFSR model seeded with 16'hACE1.
module tb_colour_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       rst_seedgen;
  logic       start;
  logic       load_colour;
  logic       flash_clk;
  logic [5:0] check_round;
  logic [5:0] current_round;
  logic [3:0] player_input;
  logic       result;
  logic [3:0] leds;
  logic [5:0] seq_len;
  logic       full;

  int checks = 0;
  int errors = 0;

  colour_seq #(.MAX_LEN(32), .SEED_INIT(16'hACE1)) dut (
    .clk(clk),
    .reset(reset),
    .rst_seedgen(rst_seedgen),
    .start(start),
    .load_colour(load_colour),
    .flash_clk(flash_clk),
    .check_round(check_round),
    .current_round(current_round),
    .player_input(player_input),
    .result(result),
    .leds(leds),
    .seq_len(seq_len),
    .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] lfsr_n(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = lfsr(v);
    return v;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic restart;
    rst_seedgen = 1'b1;
    tick();
    rst_seedgen = 1'b0;
    pulse_start();
  endtask

  task automatic load(input int n);
    load_colour = 1'b1;
    repeat (n) tick();
    load_colour = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    player_input = k;
    tick();
    player_input = 4'd0;
  endtask

  task automatic set_round(input logic [5:0] cur, input logic [5:0] chk);
    current_round = cur;
    check_round   = chk;
    #1;
  endtask

  logic [15:0] g;

  initial begin
    reset         = 1'b0;
    rst_seedgen   = 1'b0;
    start         = 1'b0;
    load_colour   = 1'b0;
    flash_clk     = 1'b1;
    check_round   = 6'd0;
    current_round = 6'd0;
    player_input  = 4'd0;
    #12;
    check("rst_len", 16'(seq_len), 16'd0);
    check("rst_res", 16'(result), 16'd0);
    check("rst_led", 16'(leds), 16'd0);
    check("rst_full", 16'(full), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    pulse_start();
    load(1);
    set_round(6'd1, 6'd1);
    check("first_led", 16'(leds), 16'h2);
    check("first_len", 16'(seq_len), 16'd1);

    press(4'b0010);
    check("hit", 16'(result), 16'd1);
    tick();
    check("hold", 16'(result), 16'd1);
    press(4'b0011);
    check("multi", 16'(result), 16'd0);
    check("fail_led", 16'(leds), 16'h3);
    flash_clk = 1'b0;
    #1;
    check("dark", 16'(leds), 16'h0);
    flash_clk = 1'b1;
    #1;

    pulse_start();
    check("clr_led", 16'(leds), 16'h0);
    check("clr_len", 16'(seq_len), 16'd0);
    load(2);
    set_round(6'd2, 6'd2);
    check("c0_led", 16'(leds), 16'h2);
    set_round(6'd2, 6'd1);
    check("c1_led", 16'(leds), 16'h8);
    press(4'b1000);
    check("c1_hit", 16'(result), 16'd1);

    set_round(6'd2, 6'd0);
    check("chk0_led", 16'(leds), 16'h0);
    set_round(6'd5, 6'd1);
    check("beyond", 16'(leds), 16'h0);
    set_round(6'd2, 6'd3);
    check("over_led", 16'(leds), 16'h0);
    press(4'b0001);
    check("over_res", 16'(result), 16'd0);

    rst_seedgen = 1'b1;
    start       = 1'b1;
    tick();
    rst_seedgen = 1'b0;
    start       = 1'b0;
    check("both_len", 16'(seq_len), 16'd2);
    set_round(6'd2, 6'd2);
    check("both_clr", 16'(leds), 16'h2);
    repeat (3) tick();
    pulse_start();
    load(1);
    set_round(6'd1, 6'd1);
`ifdef SEQ_FIXED_SEED_EN
    g = 16'hACE1;
`else
    g = lfsr_n(16'hACE1, 3);
`endif
    check("seed_run", 16'(leds), 16'(onehot(g[1:0])));

    restart();
    load(31);
    check("l31_len", 16'(seq_len), 16'd31);
    check("l31_full", 16'(full), 16'd0);
    load(2);
    check("l33_len", 16'(seq_len), 16'd32);
    check("l33_full", 16'(full), 16'd1);
    g = lfsr_n(16'hACE1, 31);
    set_round(6'd32, 6'd1);
    check("mem31", 16'(leds), 16'(onehot(g[1:0])));
    set_round(6'd32, 6'd32);
    check("mem0", 16'(leds), 16'h2);

    restart();
    load(5);
    set_round(6'd5, 6'd5);
    press(4'b0010);
    check("pre_res", 16'(result), 16'd1);
    check("pre_len", 16'(seq_len), 16'd5);
    #2;
    reset = 1'b0;
    #1;
    check("async_len", 16'(seq_len), 16'd0);
    check("async_res", 16'(result), 16'd0);
    check("async_led", 16'(leds), 16'h0);
    check("async_full", 16'(full), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    restart();
    load(1);
    set_round(6'd1, 6'd1);
    check("resume", 16'(leds), 16'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/colour_seq.md
COLOUR_SEQ -- requirements
Module: colour_seq

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32, the maximum number of stored colours (1..63).
REQ-002 SHALL have parameter SEED_INIT, default 16'hACE1, the seed-register reset value.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rst_seedgen  input  1  seed-counter restart pulse from the game FSM.
REQ-006 start  input  1  seed-capture pulse from the game FSM.
REQ-007 load_colour  input  1  append one random colour pulse from the game FSM.
REQ-008 flash_clk  input  1  LED enable level from the game FSM.
REQ-009 check_round  input  6  countdown index from the game FSM (current_round down to 1).
REQ-010 current_round  input  6  rounds started, from the game FSM.
REQ-011 player_input  input  4  one-hot colour keys, raw.
REQ-012 result  output  1  registered verdict for the latest pressed input.
REQ-013 leds  output  4  one-hot colour lamp drive.
REQ-014 seq_len  output  6  number of stored colours.
REQ-015 full  output  1  seq_len == MAX_LEN.

Function
REQ-016 SHALL hold a 16-bit Fibonacci LFSR seed register (taps 16,14,13,11) that advances every cycle between rst_seedgen and start, and loads SEED_INIT on rst_seedgen.
REQ-017 SHALL, on start, copy the seed into a generator LFSR, substituting 16'h0001 if the seed is zero, and clear seq_len to 0.
REQ-018 SHALL, on load_colour with full low, write gen[1:0] to mem[seq_len], increment seq_len, and advance gen by one step, all in the same edge.
REQ-019 SHALL ignore load_colour when full is high; seq_len saturates at MAX_LEN.
REQ-020 SHALL compute idx = current_round - check_round (6-bit); idx is valid only when 1 <= check_round <= current_round and idx < seq_len.
REQ-021 SHALL drive leds = onehot(mem[idx]) while flash_clk is high, fail_flag is low and idx is valid; 0 otherwise.
REQ-022 SHALL, each cycle with player_input nonzero, register result <= (player_input == onehot(mem[idx])) AND idx valid, and latch player_input into last_input.
REQ-023 SHALL hold result and last_input unchanged while player_input is zero.
REQ-024 SHALL treat multiple simultaneous keys as a mismatch (result 0).
REQ-025 SHALL set fail_flag on the edge that registers result 0, and clear fail_flag on rst_seedgen or start.
REQ-026 SHALL drive leds = last_input while flash_clk and fail_flag are both high.
REQ-027 SHALL give rst_seedgen priority over start and start priority over load_colour when they coincide.
REQ-028 SHALL have 1-cycle latency from player_input to result, so result is valid in the state immediately following input detection.
REQ-029 SHALL implement mem as MAX_LEN x 2-bit registers, not cleared by start.

Reset
REQ-030 SHALL, on reset low, asynchronously set the seed register to SEED_INIT, gen to 16'h0001, seq_len 0, result 0, last_input 0, fail_flag 0, leds 0, full 0.
REQ-031 SHALL resume normal operation on the first rising edge after reset deasserts, including a reset asserted mid-sequence.

Configuration
REQ-032 With SEQ_FIXED_SEED_EN defined, start SHALL load gen with SEED_INIT regardless of the seed register, giving a deterministic sequence; without it, start SHALL load gen from the seed register per REQ-017.

Verification
REQ-033 SEQ_FIXED_SEED_EN, start, load_colour x1, current_round=1, check_round=1, flash_clk=1 -> leds=4'b0010 (SEED_INIT[1:0]=01), seq_len=1.
REQ-034 After REQ-033, player_input=4'b0010 for 1 cycle -> result=1 next cycle; then 4'b0011 -> result=0, fail_flag=1, and flash_clk=1 gives leds=4'b0011.
REQ-035 Perform 33 load_colour pulses -> seq_len=32, full=1, 33rd pulse ignored, mem[31] unchanged.
REQ-036 rst_seedgen and start in the same cycle -> seed register=SEED_INIT, seq_len unchanged.
REQ-037 With check_round=0 or check_round > current_round and flash_clk=1 -> leds=0; player_input=4'b0001 -> result=0.
REQ-038 Assert reset mid-sequence with seq_len=5 and result=1 -> seq_len=0, result=0 and leds=0 immediately, without waiting for clk.
